// File: rtl/remem_cmd_issuer.sv
// rtl/remem_cmd_issuer.sv - sequences one request at a time into memristor controller instructions
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid / req_ready    request handshake; ready only while idle
//   req_op, req_addr_a/b/c   operation (001 GATE, 010 WRITE, 011 READ) and word addresses
//   req_gate, req_wb         gate function and GATE write-back enable
//   req_data                 WRITE data
//   instruction              16-bit command word to the controller (0x0000 = NOP)
//   in_data                  write data to the controller
//   in_buffer_data           current result register
//   STALL                    controller back-pressure, honoured only while issuing
//   mem_data                 registered array output, captured in CAPT
//   rsp_valid/data/err       one-cycle response strobe with result and reject flag
//   busy                     high whenever not idle
module remem_cmd_issuer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [2:0]  req_addr_a,
    input  logic [2:0]  req_addr_b,
    input  logic [2:0]  req_addr_c,
    input  logic [1:0]  req_gate,
    input  logic        req_wb,
    input  logic [7:0]  req_data,
    output logic [15:0] instruction,
    output logic [7:0]  in_data,
    output logic [7:0]  in_buffer_data,
    input  logic        STALL,
    input  logic [7:0]  mem_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPT    = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_WB_WAIT = 3'd5;
    localparam logic [2:0] S_RESP    = 3'd6;

    localparam logic [2:0] OP_GATE  = 3'b001;
    localparam logic [2:0] OP_WRITE = 3'b010;
    localparam logic [2:0] OP_READ  = 3'b011;

    logic [2:0] state;
    logic [2:0] op_q;
    logic [2:0] a_q;
    logic [2:0] b_q;
    logic [2:0] c_q;
    logic [1:0] gate_q;
    logic       wb_q;
    logic [7:0] data_q;
    logic       err_q;
    logic [7:0] result;
    logic       illegal;

    // Decoded from the live request so the reject decision is made at the acceptance edge.
    always_comb begin
        illegal = 1'b0;
        if (req_op != OP_GATE && req_op != OP_WRITE && req_op != OP_READ) begin
            illegal = 1'b1;
        end else if (req_op == OP_GATE && req_gate == 2'b11) begin
            illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= 3'd0;
            a_q    <= 3'd0;
            b_q    <= 3'd0;
            c_q    <= 3'd0;
            gate_q <= 2'd0;
            wb_q   <= 1'b0;
            data_q <= 8'd0;
            err_q  <= 1'b0;
            result <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        a_q    <= req_addr_a;
                        b_q    <= req_addr_b;
                        c_q    <= req_addr_c;
                        gate_q <= req_gate;
                        wb_q   <= req_wb;
                        data_q <= req_data;
                        err_q  <= illegal;
                        state  <= illegal ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE:   if (!STALL) state <= S_WAIT;
                S_WAIT:    state <= (op_q == OP_WRITE) ? S_RESP : S_CAPT;
                S_CAPT: begin
                    result <= mem_data;
                    state  <= (op_q == OP_GATE && wb_q) ? S_WB : S_RESP;
                end
                S_WB:      if (!STALL) state <= S_WB_WAIT;
                S_WB_WAIT: state <= S_RESP;
                S_RESP:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // All outputs decode only registered state, so nothing on req_* or mem_data
    // reaches the controller or response side combinationally.
    always_comb begin
        instruction = 16'h0000;
        in_data     = 8'h00;
        if (state == S_ISSUE) begin
            case (op_q)
                OP_WRITE: begin
                    instruction = {OP_WRITE, a_q, 10'd0};
                    in_data     = data_q;
                end
                OP_READ:  instruction = {OP_READ, 3'd0, 3'd0, 2'b00, 2'b00, c_q};
                OP_GATE:  instruction = {OP_GATE, a_q, b_q, 2'b00, gate_q, c_q};
                default:  instruction = 16'h0000;
            endcase
        end else if (state == S_WB) begin
            // Write-back reuses the WRITE encoding with the destination in the A field.
            instruction = {OP_WRITE, c_q, 10'd0};
            in_data     = result;
        end
    end

    assign req_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign in_buffer_data = result;
    assign rsp_valid      = (state == S_RESP);
    assign rsp_err        = (state == S_RESP) && err_q;
    assign rsp_data       = ((state == S_RESP) && !err_q && op_q != OP_WRITE) ? result : 8'h00;

endmodule

// File: tb/tb_remem_cmd_issuer.sv
// tb/tb_remem_cmd_issuer.sv - self-checking bench for remem_cmd_issuer
module tb_remem_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [2:0]  req_addr_a;
    logic [2:0]  req_addr_b;
    logic [2:0]  req_addr_c;
    logic [1:0]  req_gate;
    logic        req_wb;
    logic [7:0]  req_data;
    logic [15:0] instruction;
    logic [7:0]  in_data;
    logic [7:0]  in_buffer_data;
    logic        STALL;
    logic [7:0]  mem_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    remem_cmd_issuer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_addr_c(req_addr_c),
        .req_gate(req_gate), .req_wb(req_wb), .req_data(req_data),
        .instruction(instruction), .in_data(in_data), .in_buffer_data(in_buffer_data),
        .STALL(STALL), .mem_data(mem_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // Presents one request for exactly one edge; returns #1 after the acceptance edge.
    task automatic drive_req(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                             input logic [2:0] c, input logic [1:0] g, input logic wb,
                             input logic [7:0] d);
        @(posedge clk); #1;
        req_op = op; req_addr_a = a; req_addr_b = b; req_addr_c = c;
        req_gate = g; req_wb = wb; req_data = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Bounded wait for rsp_valid; also records the first WRITE-opcode instruction seen.
    task automatic wait_rsp(input int start, input int limit, output bit got, output int lat,
                            output logic [7:0] d, output logic e, output bit wr_seen,
                            output logic [15:0] wr_i, output logic [7:0] wr_d,
                            output logic [7:0] wr_b);
        got = 0; wr_seen = 0; lat = start; d = 8'h00; e = 1'b0;
        wr_i = 16'h0000; wr_d = 8'h00; wr_b = 8'h00;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (instruction[15:13] == 3'b010 && !wr_seen) begin
                wr_seen = 1; wr_i = instruction; wr_d = in_data; wr_b = in_buffer_data;
            end
            if (rsp_valid) begin
                got = 1; d = rsp_data; e = rsp_err;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    bit got; int lat; logic [7:0] d; logic e; bit ws; logic [15:0] wi; logic [7:0] wd; logic [7:0] wb;
    exp_t ex;

    task automatic test_reset();
        rst = 1'b1; STALL = 1'b0; mem_data = 8'h00;
        req_valid = 1'b1; req_op = 3'b010; req_addr_a = 3'd1; req_addr_b = 3'd0; req_addr_c = 3'd0;
        req_gate = 2'd0; req_wb = 1'b0; req_data = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy_priority got %b exp 0", busy); else passed++;
        total++; if (instruction !== 16'h0000) $display("FAIL reset_instr got %h exp 0000", instruction); else passed++;
        total++; if (in_data !== 8'h00) $display("FAIL reset_in_data got %h exp 00", in_data); else passed++;
        total++; if (in_buffer_data !== 8'h00) $display("FAIL reset_buf got %h exp 00", in_buffer_data); else passed++;
        total++; if ({rsp_valid, rsp_err, rsp_data} !== 10'd0) $display("FAIL reset_rsp got %b%b %h exp 00 00", rsp_valid, rsp_err, rsp_data); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else passed++;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write();
        mem_data = 8'h00;
        drive_req(3'b010, 3'd3, 3'd6, 3'd7, 2'b10, 1'b1, 8'hA5);
        sb.push_back('{8'h00, 1'b0, 3});
        wait_rsp(1, 20, got, lat, d, e, ws, wi, wd, wb);
        ex = sb.pop_front();
        total++; if (wi !== 16'h4C00) $display("FAIL write_instr got %h exp 4c00", wi); else passed++;
        total++; if (wd !== 8'hA5) $display("FAIL write_in_data got %h exp a5", wd); else passed++;
        total++; if (got !== 1'b1) $display("FAIL write_timeout got %b exp 1", got); else passed++;
        total++; if (lat !== ex.lat) $display("FAIL write_lat got %0d exp %0d", lat, ex.lat); else passed++;
        total++; if ({e, d} !== {ex.err, ex.data}) $display("FAIL write_rsp got %b %h exp %b %h", e, d, ex.err, ex.data); else passed++;
    endtask

    task automatic test_read();
        mem_data = 8'hA5;
        drive_req(3'b011, 3'd5, 3'd6, 3'd3, 2'b01, 1'b1, 8'h33);
        sb.push_back('{8'hA5, 1'b0, 4});
        total++; if (instruction !== 16'h6003) $display("FAIL read_instr got %h exp 6003", instruction); else passed++;
        total++; if (in_data !== 8'h00) $display("FAIL read_in_data got %h exp 00", in_data); else passed++;
        wait_rsp(1, 20, got, lat, d, e, ws, wi, wd, wb);
        ex = sb.pop_front();
        total++; if (got !== 1'b1 || lat !== ex.lat) $display("FAIL read_lat got %b/%0d exp 1/%0d", got, lat, ex.lat); else passed++;
        total++; if ({e, d} !== {ex.err, ex.data}) $display("FAIL read_rsp got %b %h exp %b %h", e, d, ex.err, ex.data); else passed++;
    endtask

    task automatic test_gate_wb();
        mem_data = 8'h21;
        drive_req(3'b001, 3'd1, 3'd2, 3'd5, 2'b01, 1'b1, 8'h00);
        sb.push_back('{8'h21, 1'b0, 6});
        total++; if (instruction !== 16'h250D) $display("FAIL gate_instr got %h exp 250d", instruction); else passed++;
        wait_rsp(1, 20, got, lat, d, e, ws, wi, wd, wb);
        ex = sb.pop_front();
        total++; if (ws !== 1'b1 || wi !== 16'h5400) $display("FAIL gate_wb_instr got %b/%h exp 1/5400", ws, wi); else passed++;
        total++; if (wd !== 8'h21 || wb !== 8'h21) $display("FAIL gate_wb_data got %h/%h exp 21/21", wd, wb); else passed++;
        total++; if (got !== 1'b1 || lat !== ex.lat) $display("FAIL gate_wb_lat got %b/%0d exp 1/%0d", got, lat, ex.lat); else passed++;
        total++; if ({e, d} !== {ex.err, ex.data}) $display("FAIL gate_wb_rsp got %b %h exp %b %h", e, d, ex.err, ex.data); else passed++;
    endtask

    task automatic test_gate_nowb();
        mem_data = 8'h3C;
        drive_req(3'b001, 3'd7, 3'd0, 3'd2, 2'b10, 1'b0, 8'h99);
        sb.push_back('{8'h3C, 1'b0, 4});
        total++; if (instruction !== 16'h3C12) $display("FAIL gate_xor_instr got %h exp 3c12", instruction); else passed++;
        wait_rsp(1, 20, got, lat, d, e, ws, wi, wd, wb);
        ex = sb.pop_front();
        total++; if (ws !== 1'b0) $display("FAIL gate_nowb_write got %b exp 0", ws); else passed++;
        total++; if (got !== 1'b1 || lat !== ex.lat) $display("FAIL gate_nowb_lat got %b/%0d exp 1/%0d", got, lat, ex.lat); else passed++;
        total++; if ({e, d} !== {ex.err, ex.data}) $display("FAIL gate_nowb_rsp got %b %h exp %b %h", e, d, ex.err, ex.data); else passed++;
    endtask

    task automatic test_stall();
        mem_data = 8'h5A;
        STALL = 1'b1;
        drive_req(3'b011, 3'd0, 3'd0, 3'd3, 2'b00, 1'b0, 8'h00);
        sb.push_back('{8'h5A, 1'b0, 7});
        for (int i = 0; i < 3; i++) begin
            total++; if (instruction !== 16'h6003) $display("FAIL stall_hold%0d got %h exp 6003", i, instruction); else passed++;
            @(posedge clk); #1;
        end
        STALL = 1'b0;
        wait_rsp(4, 20, got, lat, d, e, ws, wi, wd, wb);
        ex = sb.pop_front();
        total++; if (got !== 1'b1 || lat !== ex.lat) $display("FAIL stall_lat got %b/%0d exp 1/%0d", got, lat, ex.lat); else passed++;
        total++; if ({e, d} !== {ex.err, ex.data}) $display("FAIL stall_rsp got %b %h exp %b %h", e, d, ex.err, ex.data); else passed++;
    endtask

    task automatic test_illegal();
        drive_req(3'b111, 3'd1, 3'd1, 3'd1, 2'b00, 1'b0, 8'h12);
        sb.push_back('{8'h00, 1'b1, 1});
        total++; if (instruction !== 16'h0000) $display("FAIL illegal_instr got %h exp 0000", instruction); else passed++;
        wait_rsp(1, 20, got, lat, d, e, ws, wi, wd, wb);
        ex = sb.pop_front();
        total++; if (got !== 1'b1 || lat !== ex.lat) $display("FAIL illegal_lat got %b/%0d exp 1/%0d", got, lat, ex.lat); else passed++;
        total++; if ({e, d} !== {ex.err, ex.data}) $display("FAIL illegal_rsp got %b %h exp %b %h", e, d, ex.err, ex.data); else passed++;
        drive_req(3'b001, 3'd1, 3'd2, 3'd3, 2'b11, 1'b0, 8'h00);
        sb.push_back('{8'h00, 1'b1, 1});
        wait_rsp(1, 20, got, lat, d, e, ws, wi, wd, wb);
        ex = sb.pop_front();
        total++; if (got !== 1'b1 || lat !== ex.lat || e !== ex.err) $display("FAIL gate11_rsp got %b/%0d/%b exp 1/%0d/%b", got, lat, e, ex.lat, ex.err); else passed++;
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        req_op = 3'b000; req_addr_a = 3'd0; req_addr_b = 3'd0; req_addr_c = 3'd0;
        req_gate = 2'd0; req_wb = 1'b0; req_data = 8'h00; req_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || req_ready !== 1'b0) $display("FAIL b2b_resp got v%b e%b r%b exp v1 e1 r0", rsp_valid, rsp_err, req_ready); else passed++;
        req_op = 3'b010; req_addr_a = 3'd2; req_data = 8'h11;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_idle got busy%b ready%b exp 0 1", busy, req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb.push_back('{8'h00, 1'b0, 3});
        total++; if (instruction !== 16'h4800 || in_data !== 8'h11) $display("FAIL b2b_instr got %h/%h exp 4800/11", instruction, in_data); else passed++;
        wait_rsp(1, 20, got, lat, d, e, ws, wi, wd, wb);
        ex = sb.pop_front();
        total++; if (got !== 1'b1 || lat !== ex.lat || d !== ex.data) $display("FAIL b2b_lat got %b/%0d/%h exp 1/%0d/%h", got, lat, d, ex.lat, ex.data); else passed++;
    endtask

    task automatic test_reset_mid();
        mem_data = 8'h77;
        drive_req(3'b001, 3'd1, 3'd2, 3'd5, 2'b00, 1'b1, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got %b exp 1", busy); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (busy !== 1'b0 || instruction !== 16'h0000) $display("FAIL rstmid_idle got busy%b %h exp 0 0000", busy, instruction); else passed++;
        total++; if (in_buffer_data !== 8'h00) $display("FAIL rstmid_result got %h exp 00", in_buffer_data); else passed++;
        wait_rsp(1, 10, got, lat, d, e, ws, wi, wd, wb);
        total++; if (got !== 1'b0) $display("FAIL rstmid_no_rsp got %b exp 0", got); else passed++;
        total++; if (ws !== 1'b0) $display("FAIL rstmid_no_write got %b (%h) exp 0", ws, wi); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_gate_wb();
        test_gate_nowb();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
